// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel,
// branch redirect, and the IF/ID slot handshake toward decode.
//   master : the fetch stage (drives imem_req/addr and the id_* slot)
//   slave  : the environment (memory, branch unit, decode)
interface fetch_stage_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ready_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            id_valid_o;
  logic [XLEN-1:0] id_pc_o;
  logic [XLEN-1:0] id_inst_o;
  logic            id_ready_i;

  modport master (
    output imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o,
    input  imem_ready_i, imem_rvalid_i, imem_rdata_i,
           redirect_i, redirect_pc_i, id_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o,
    output imem_ready_i, imem_rvalid_i, imem_rdata_i,
           redirect_i, redirect_pc_i, id_ready_i
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage with IF/ID pipeline register.
// Keeps the PC, issues one word fetch at a time over req/ready + rvalid,
// presents {pc, inst} to decode and absorbs decode back-pressure with a
// one-entry hold buffer. Redirects flush the slot and discard any response
// still in flight.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (master)        imem_* fetch channel, redirect_*, id_* slot
//   perf_fetched_o/perf_stall_o  event counters (FETCH_PERF_CNT_EN only)
// Optional feature macro: FETCH_PERF_CNT_EN
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_stage_if.master   bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_stall_o
`endif
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_id_valid;
  logic [XLEN-1:0] r_id_pc;
  logic [XLEN-1:0] r_id_inst;
  logic [XLEN-1:0] r_hold_pc;
  logic [XLEN-1:0] r_hold_inst;

  logic            w_slot_free;
  logic            w_consume;
  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_pc_inc;

  assign w_slot_free   = ~r_id_valid | bus.id_ready_i;
  assign w_consume     = r_id_valid & bus.id_ready_i;
  assign w_redirect_pc = bus.redirect_pc_i & ~XLEN'(3);
  assign w_pc_inc      = r_pc + XLEN'(4);

  // Request is suppressed in the redirect cycle so no fetch of the stale PC is launched.
  assign bus.imem_req_o  = (r_state == S_REQ) & ~bus.redirect_i;
  assign bus.imem_addr_o = r_pc;
  assign bus.id_valid_o  = r_id_valid;
  assign bus.id_pc_o     = r_id_pc;
  assign bus.id_inst_o   = r_id_inst;

  // Fetch FSM, PC, IF/ID slot and hold buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_id_valid  <= 1'b0;
      r_id_pc     <= '0;
      r_id_inst   <= NOP_INST;
      r_hold_pc   <= '0;
      r_hold_inst <= NOP_INST;
    end else if (bus.redirect_i) begin
      r_pc        <= w_redirect_pc;
      r_id_valid  <= 1'b0;
      r_id_inst   <= NOP_INST;
      r_hold_pc   <= '0;
      r_hold_inst <= NOP_INST;
      // A response still owed by memory must be swallowed in S_DROP.
      case (r_state)
        S_WAIT, S_DROP: r_state <= bus.imem_rvalid_i ? S_REQ : S_DROP;
        default:        r_state <= S_REQ;
      endcase
    end else begin
      // Consumed slot empties unless a reload below overrides it.
      if (w_consume) begin
        r_id_valid <= 1'b0;
        r_id_inst  <= NOP_INST;
      end
      case (r_state)
        S_REQ: begin
          if (bus.imem_ready_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.imem_rvalid_i) begin
            r_pc <= w_pc_inc;
            if (w_slot_free) begin
              r_id_valid <= 1'b1;
              r_id_pc    <= r_pc;
              r_id_inst  <= bus.imem_rdata_i;
              r_state    <= S_REQ;
            end else begin
              r_hold_pc   <= r_pc;
              r_hold_inst <= bus.imem_rdata_i;
              r_state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_slot_free) begin
            r_id_valid <= 1'b1;
            r_id_pc    <= r_hold_pc;
            r_id_inst  <= r_hold_inst;
            r_state    <= S_REQ;
          end
        end
        S_DROP: begin
          if (bus.imem_rvalid_i) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  // Handshake and back-pressure counters, free-running modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (r_id_valid & bus.id_ready_i)  r_perf_fetched <= r_perf_fetched + 32'd1;
      if (r_id_valid & ~bus.id_ready_i) r_perf_stall   <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched_o = r_perf_fetched;
  assign perf_stall_o   = r_perf_stall;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;

  fetch_stage_if bus_if();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] exp_fetched;
  logic [31:0] exp_stall;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched_o (perf_fetched),
    .perf_stall_o   (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_hs  = 0;

  logic [31:0] exp_q[$];   // expected PCs of the instructions decode will receive
  logic [31:0] acc_q[$];   // addresses accepted by the memory model
  logic [31:0] gen_pc;

  int unsigned mem_lat_max   = 1;
  int unsigned mem_ready_pct = 100;
  bit          mem_out;
  int unsigned mem_cnt;
  logic [31:0] mem_addr;

  function automatic logic [31:0] f_inst(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the driving slot of the next cycle and keep the expected stream topped up.
  task automatic step();
    @(negedge clk);
    #1;
    while (exp_q.size() < 2) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic apply(input bit redir, input logic [31:0] tgt, input bit rdy);
    bus_if.id_ready_i    = rdy;
    bus_if.redirect_i    = redir;
    bus_if.redirect_pc_i = tgt;
    if (redir) gen_pc = tgt & ~32'd3;
  endtask

  task automatic drive(input bit redir, input logic [31:0] tgt, input bit rdy);
    step();
    apply(redir, tgt, rdy);
  endtask

  // Memory model: drives ready/rvalid at the falling edge, books accepts before the rising edge.
  initial begin
    bus_if.imem_ready_i  = 1'b0;
    bus_if.imem_rvalid_i = 1'b0;
    bus_if.imem_rdata_i  = '0;
    mem_out  = 1'b0;
    mem_cnt  = 0;
    mem_addr = '0;
    forever begin
      @(negedge clk);
      bus_if.imem_ready_i = ($urandom_range(99, 0) < mem_ready_pct);
      if (!rst_n) begin
        mem_out = 1'b0;
        bus_if.imem_rvalid_i = 1'b0;
      end else begin
        bus_if.imem_rvalid_i = 1'b0;
        if (mem_out && mem_cnt > 0) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            bus_if.imem_rvalid_i = 1'b1;
            bus_if.imem_rdata_i  = f_inst(mem_addr);
          end
        end
      end
      #3;
      if (rst_n) begin
        if (bus_if.imem_req_o) begin
          check32("req_while_outstanding", 32'(mem_out), 32'd0);
          check32("req_during_redirect", 32'(bus_if.redirect_i), 32'd0);
        end
        if (bus_if.imem_rvalid_i) mem_out = 1'b0;
        if (bus_if.imem_req_o && bus_if.imem_ready_i) begin
          mem_out  = 1'b1;
          mem_addr = bus_if.imem_addr_o;
          mem_cnt  = $urandom_range(mem_lat_max, 1);
          acc_q.push_back(bus_if.imem_addr_o);
        end
      end
    end
  end

  // Monitor: pops the scoreboard for every decode handshake about to happen.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        if (bus_if.id_valid_o && bus_if.id_ready_i) begin
          n_hs++;
`ifdef FETCH_PERF_CNT_EN
          exp_fetched = exp_fetched + 32'd1;
`endif
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_underflow: got pc %08h expected no instruction", bus_if.id_pc_o);
          end else begin
            e = exp_q.pop_front();
            check32("id_pc", bus_if.id_pc_o, e);
            check32("id_inst", bus_if.id_inst_o, f_inst(e));
          end
        end
`ifdef FETCH_PERF_CNT_EN
        if (bus_if.id_valid_o && !bus_if.id_ready_i) exp_stall = exp_stall + 32'd1;
`endif
        if (!bus_if.id_valid_o) check32("id_inst_empty_nop", bus_if.id_inst_o, NOP);
        if (bus_if.redirect_i) exp_q.delete();
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic redirect_check(input string name, input logic [31:0] tgt,
                                input logic [31:0] e0, input logic [31:0] e1, input bit on_rvalid);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      if (on_rvalid ? (bus_if.imem_rvalid_i === 1'b1)
                    : (mem_out && bus_if.imem_rvalid_i === 1'b0)) begin
        hit = 1'b1;
        acc_q.delete();
        apply(1'b1, tgt, 1'b1);
      end else begin
        apply(1'b0, '0, 1'b1);
      end
    end
    check32({name, "_arm_timeout"}, 32'(hit), 32'd1);
    if (!hit) return;
    if (on_rvalid) begin
      step();
      apply(1'b0, '0, 1'b1);
      #1;
      check32({name, "_req_next"}, 32'(bus_if.imem_req_o), 32'd1);
      check32({name, "_addr_next"}, bus_if.imem_addr_o, e0);
    end
    for (int i = 0; i < 80 && acc_q.size() < 2; i++) drive(1'b0, '0, 1'b1);
    check32({name, "_fetch_timeout"}, 32'(acc_q.size() >= 2), 32'd1);
    if (acc_q.size() >= 2) begin
      check32({name, "_addr0"}, acc_q[0], e0);
      check32({name, "_addr1"}, acc_q[1], e1);
    end
  endtask

  initial begin
    int h0;
    int a0;
    bus_if.id_ready_i    = 1'b0;
    bus_if.redirect_i    = 1'b0;
    bus_if.redirect_pc_i = '0;
    rst_n  = 1'b0;
    gen_pc = 32'h0;
`ifdef FETCH_PERF_CNT_EN
    exp_fetched = '0;
    exp_stall   = '0;
`endif

    // Reset state
    repeat (2) step();
    check32("rst_id_valid", 32'(bus_if.id_valid_o), 32'd0);
    check32("rst_id_pc", bus_if.id_pc_o, 32'h0);
    check32("rst_id_inst", bus_if.id_inst_o, NOP);
    check32("rst_addr", bus_if.imem_addr_o, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check32("rst_perf_fetched", perf_fetched, 32'd0);
    check32("rst_perf_stall", perf_stall, 32'd0);
`endif
    apply(1'b0, '0, 1'b1);
    acc_q.delete();
    step();
    rst_n = 1'b1;
    apply(1'b0, '0, 1'b1);

    // Streaming: 1-cycle latency, always ready -> one instruction every two cycles
    repeat (11) drive(1'b0, '0, 1'b1);
    check32("stream_handshakes", 32'(n_hs), 32'd5);
    if (acc_q.size() >= 3) begin
      check32("stream_addr0", acc_q[0], 32'h0);
      check32("stream_addr1", acc_q[1], 32'h4);
      check32("stream_addr2", acc_q[2], 32'h8);
    end else begin
      check32("stream_accepts", 32'(acc_q.size()), 32'd3);
    end

    // Decode back-pressure fills slot and hold buffer, then drains with no bubble
    a0 = acc_q.size();
    repeat (6) drive(1'b0, '0, 1'b0);
    check32("stall_valid", 32'(bus_if.id_valid_o), 32'd1);
    check32("stall_accepts", 32'(acc_q.size() - a0), 32'd1);
    h0 = n_hs;
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    check32("drain_first", 32'(n_hs - h0), 32'd1);
    drive(1'b0, '0, 1'b1);
    check32("drain_second", 32'(n_hs - h0), 32'd2);

    // Redirect corner cases
    mem_lat_max = 3;
    redirect_check("redir_wait", 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 1'b0);
    mem_lat_max = 1;
    redirect_check("redir_rvalid", 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 1'b1);
    mem_lat_max = 2;
    redirect_check("redir_align", 32'h0000_0203, 32'h0000_0200, 32'h0000_0204, 1'b0);
    redirect_check("redir_wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);

    // Randomized traffic
    mem_lat_max   = 4;
    mem_ready_pct = 60;
    h0 = n_hs;
    for (int i = 0; i < 2500; i++) begin
      bit          r;
      logic [31:0] t;
      step();
      r = ($urandom_range(19, 0) == 0);
      case ($urandom_range(3, 0))
        0:       t = 32'h0000_0100;
        1:       t = 32'h0000_0203;
        2:       t = 32'hFFFF_FFF8;
        default: t = $urandom;
      endcase
      apply(r, t, $urandom_range(9, 0) < 7);
    end
    check32("random_progress", 32'((n_hs - h0) > 100), 32'd1);

    // Asynchronous reset mid-run
    step();
    apply(1'b0, '0, 1'b1);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    gen_pc = 32'h0;
`ifdef FETCH_PERF_CNT_EN
    exp_fetched = '0;
    exp_stall   = '0;
`endif
    #1;
    check32("midrst_id_valid", 32'(bus_if.id_valid_o), 32'd0);
    check32("midrst_id_inst", bus_if.id_inst_o, NOP);
    check32("midrst_addr", bus_if.imem_addr_o, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check32("midrst_perf_fetched", perf_fetched, 32'd0);
    check32("midrst_perf_stall", perf_stall, 32'd0);
`endif
    repeat (2) drive(1'b0, '0, 1'b1);
    step();
    rst_n = 1'b1;
    apply(1'b0, '0, 1'b1);

    h0 = n_hs;
    for (int i = 0; i < 300; i++) drive(1'b0, '0, $urandom_range(9, 0) < 6);
    check32("post_reset_progress", 32'((n_hs - h0) > 10), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check32("perf_fetched", perf_fetched, exp_fetched);
    check32("perf_stall", perf_stall, exp_stall);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage with IF/ID pipeline register for the 32-bit RV32I core. Holds the PC and issues word fetches to instruction memory over a req/ready + rvalid handshake, one request outstanding at most. Presents {pc, inst} to decode; the decode stage's immediate generator consumes id_inst_o. Handles decode back-pressure and branch/jump redirects, discarding stale responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, id_inst_o value when the slot is empty (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_o  out  1  fetch request valid
imem_addr_o  out  32  fetch address (word aligned)
imem_ready_i  in  1  memory accepts the request this cycle
imem_rvalid_i  in  1  response valid (arrives at least 1 cycle after acceptance)
imem_rdata_i  in  32  instruction word
redirect_i  in  1  taken branch/jump: flush and refetch
redirect_pc_i  in  32  new PC; bits [1:0] are ignored and forced to 2'b00
id_valid_o  out  1  IF/ID slot holds a valid instruction
id_pc_o  out  32  PC of id_inst_o
id_inst_o  out  32  fetched instruction
id_ready_i  in  1  decode consumes the slot this cycle

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC; state=S_REQ.
  - id_valid_o=0, id_pc_o=0, id_inst_o=NOP_INST, hold buffer empty.
  - imem_req_o is combinational, so it rises in the first cycle after release.
- Outputs:
  - imem_req_o=1 only in S_REQ and only when redirect_i=0.
  - imem_addr_o=pc.
- The IF/ID slot is free when id_valid_o=0 or id_ready_i=1.
- While id_valid_o=1 and id_ready_i=0, id_pc_o and id_inst_o hold stable.
- On a consume with no reload, id_valid_o goes to 0 and id_inst_o returns to NOP_INST.
- Fetch latency: request accepted in cycle N, rvalid in cycle N+k (k≥1), data visible on id_* from cycle N+k+1 if the slot is free.
- FSM transitions:
  - S_REQ: accepted (imem_ready_i=1) -> S_WAIT.
  - S_WAIT: rvalid with slot free -> load id_* from {pc, rdata}, pc+=4, -> S_REQ.
  - S_WAIT: rvalid with slot occupied -> capture {pc, rdata} into the hold buffer, pc+=4, -> S_HOLD.
  - S_HOLD: when the slot frees, move hold into id_* (id_valid_o stays 1), -> S_REQ.
  - S_DROP: on rvalid discard the data, no id_* update, -> S_REQ.
- PC arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Redirect has highest priority over all of the above:
  - Effects in every state: pc<=redirect_pc_i&~3, id_valid_o<=0, id_inst_o<=NOP_INST, hold buffer cleared.
  - State after redirect:
    - From S_REQ (no request issued, since imem_req_o=0 that cycle) -> S_REQ.
    - From S_WAIT without rvalid -> S_DROP; with rvalid the same cycle, the response is discarded -> S_REQ.
    - From S_DROP without rvalid -> S_DROP; with rvalid -> S_REQ.
    - From S_HOLD -> S_REQ.
- Redirect and id_ready_i in the same cycle: redirect wins; the consumed instruction is still considered taken by decode.
- Only one request is ever outstanding. No request is issued in S_WAIT, S_HOLD or S_DROP.
- Reset mid-transaction: all state clears. Memory must itself drop any in-flight response on reset.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds ports perf_fetched_o (out, 32) and perf_stall_o (out, 32), both reset to 0 and wrapping modulo 2^32.
  - perf_fetched_o increments on each id_valid_o & id_ready_i handshake.
  - perf_stall_o increments each cycle id_valid_o=1 & id_ready_i=0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, imem_ready_i=1, 1-cycle latency, id_ready_i=1, rdata=pc^32'hA5A5_0000 -> imem_addr_o sequence 0x0,0x4,0x8; id_pc_o/id_inst_o follow with one fetch every 2 cycles; id_inst_o=NOP_INST before the first fetch.
- id_ready_i=0 for 5 cycles while the instruction at 0x4 is in the slot and the fetch of 0x8 returns -> id_* holds 0x4 stable and FSM enters S_HOLD; after id_ready_i=1, 0x8 appears the next cycle with no bubble and no lost or duplicated instruction.
- Redirect to 0x100 in S_WAIT, response for 0x8 arriving 3 cycles later -> response is dropped, next imem_addr_o=0x100, and id_valid_o=0 until data for 0x100 arrives.
- Redirect in the same cycle as imem_rvalid_i -> data discarded, imem_req_o with addr 0x100 next cycle.
- redirect_pc_i=0x0000_0203 -> fetch address 0x0000_0200; with pc=0xFFFF_FFFC, the next fetch is 0x0.
- With FETCH_PERF_CNT_EN: 10 consumed instructions and 4 stalled cycles -> perf_fetched_o=10, perf_stall_o=4; rst_n pulse mid-run -> both counters 0 and pc=RESET_PC immediately.
